clk_wiz: RTL and testbench

Reconfigurable pixel-clock generator with an AXI4-Lite control slave, used by the VGA clock-control FSM to retune the pixel clock per resolution. It holds the output-frequency register, applies new settings on a load command, and drops `locked` for a fixed relock interval around each change. `clk_out1` is a behavioral, delay-based clock model with a 1 ps timescale; the AXI slave and lock sequencer are synthesizable RTL.

---
 rtl/clk_wiz_pkg.sv | 31 +++
 rtl/clk_wiz_axil_regs.sv | 124 ++++++++++++
 rtl/clk_wiz.sv | 123 ++++++++++++
 tb/tb_clk_wiz.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/clk_wiz_pkg.sv
`timescale 1ps/1ps
// Shared constants, types and helpers for the clk_wiz pixel-clock generator.
package clk_wiz_pkg;

  localparam logic [10:0] ADDR_SRR    = 11'h000;
  localparam logic [10:0] ADDR_STATUS = 11'h004;
  localparam logic [10:0] ADDR_CFG    = 11'h208;
  localparam logic [10:0] ADDR_CTRL   = 11'h25C;

  localparam logic [17:0] CFG_RST = 18'h00064;
  localparam logic [31:0] SRR_KEY = 32'h0000_000A;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {StRelock, StRun} lock_state_e;

  function automatic logic cfg_legal(input logic [17:0] cfg, input int unsigned fmin,
                                     input int unsigned fmax);
    return (32'(cfg[7:0]) >= fmin) && (32'(cfg[7:0]) <= fmax) && (cfg[17:8] <= 10'd999);
  endfunction

  // Half-period in ps, rounded to nearest: 5e8 / (MHz * 1000).
  function automatic int unsigned half_period_ps(input logic [17:0] cfg);
    int unsigned d;
    d = 32'(cfg[7:0]) * 32'd1000 + 32'(cfg[17:8]);
    if (d == 0) d = 1;
    return (32'd500_000_000 + d / 2) / d;
  endfunction

endpackage

// File: rtl/clk_wiz_axil_regs.sv
`timescale 1ps/1ps
// AXI4-Lite control slave for clk_wiz: register file, CFG legality check and load requests.
module clk_wiz_axil_regs
  import clk_wiz_pkg::*;
#(
  parameter int unsigned FREQ_MIN = 10,
  parameter int unsigned FREQ_MAX = 200
) (
  input  logic        clk_100m_i,
  input  logic        arstn_i,
  input  logic [10:0] s_axi_awaddr,
  input  logic        s_axi_awvalid,
  output logic        s_axi_awready,
  input  logic [31:0] s_axi_wdata,
  input  logic [3:0]  s_axi_wstrb,
  input  logic        s_axi_wvalid,
  output logic        s_axi_wready,
  output logic [1:0]  s_axi_bresp,
  output logic        s_axi_bvalid,
  input  logic        s_axi_bready,
  input  logic [10:0] s_axi_araddr,
  input  logic        s_axi_arvalid,
  output logic        s_axi_arready,
  output logic [31:0] s_axi_rdata,
  output logic [1:0]  s_axi_rresp,
  output logic        s_axi_rvalid,
  input  logic        s_axi_rready,
  input  logic        locked_i,
  output logic        load_o,
  output logic [17:0] load_cfg_o
);

  logic [17:0] cfg_q, cfg_d, cfg_merged;
  logic        saddr_q, saddr_d;
  logic        bvalid_q, rvalid_q;
  logic [1:0]  bresp_q, bresp_d, rresp_q, rresp_d;
  logic [31:0] rdata_q, rdata_d;
  logic        wr_en, rd_en, soft_rst, ctrl_load;

  // Ready lines stay low while reset is asserted.
  assign s_axi_awready = arstn_i & ~bvalid_q;
  assign s_axi_wready  = arstn_i & ~bvalid_q;
  assign s_axi_arready = arstn_i & ~rvalid_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bresp   = bresp_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rresp   = rresp_q;
  assign s_axi_rdata   = rdata_q;

  assign wr_en = s_axi_awvalid & s_axi_wvalid & ~bvalid_q;
  assign rd_en = s_axi_arvalid & ~rvalid_q;

  always_comb begin
    cfg_merged = cfg_q;
    if (s_axi_wstrb[0]) cfg_merged[7:0]   = s_axi_wdata[7:0];
    if (s_axi_wstrb[1]) cfg_merged[15:8]  = s_axi_wdata[15:8];
    if (s_axi_wstrb[2]) cfg_merged[17:16] = s_axi_wdata[17:16];
    cfg_d     = cfg_q;
    saddr_d   = saddr_q;
    bresp_d   = RESP_OKAY;
    soft_rst  = 1'b0;
    ctrl_load = 1'b0;
    if (wr_en) begin
      case (s_axi_awaddr)
        ADDR_SRR:  soft_rst = (s_axi_wstrb == 4'hF) && (s_axi_wdata == SRR_KEY);
        ADDR_CFG: begin
          if (cfg_legal(cfg_merged, FREQ_MIN, FREQ_MAX)) cfg_d = cfg_merged;
          else bresp_d = RESP_SLVERR;
        end
        ADDR_CTRL: begin
          if (s_axi_wstrb[0]) begin
            saddr_d   = s_axi_wdata[1];
            ctrl_load = s_axi_wdata[0];
          end
        end
        default:   bresp_d = RESP_SLVERR;
      endcase
    end
    if (soft_rst) cfg_d = CFG_RST;
  end

  assign load_o     = ctrl_load | soft_rst;
  assign load_cfg_o = soft_rst ? CFG_RST : cfg_q;

  always_comb begin
    rdata_d = '0;
    rresp_d = RESP_OKAY;
    case (s_axi_araddr)
      ADDR_STATUS: rdata_d = {31'b0, locked_i};
      ADDR_CFG:    rdata_d = {14'b0, cfg_q};
      ADDR_CTRL:   rdata_d = {30'b0, saddr_q, 1'b0};
      default:     rresp_d = RESP_SLVERR;
    endcase
  end

  always_ff @(posedge clk_100m_i or negedge arstn_i) begin
    if (!arstn_i) begin
      cfg_q    <= CFG_RST;
      saddr_q  <= 1'b0;
      bvalid_q <= 1'b0;
      bresp_q  <= RESP_OKAY;
      rvalid_q <= 1'b0;
      rresp_q  <= RESP_OKAY;
      rdata_q  <= '0;
    end else begin
      cfg_q   <= cfg_d;
      saddr_q <= saddr_d;
      if (wr_en) begin
        bvalid_q <= 1'b1;
        bresp_q  <= bresp_d;
      end else if (s_axi_bready) begin
        bvalid_q <= 1'b0;
      end
      if (rd_en) begin
        rvalid_q <= 1'b1;
        rresp_q  <= rresp_d;
        rdata_q  <= rdata_d;
      end else if (s_axi_rready) begin
        rvalid_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/clk_wiz.sv
`timescale 1ps/1ps
// Reconfigurable pixel-clock generator: AXI4-Lite control, relock sequencer and a
// behavioral delay-based model of the generated clock.
module clk_wiz
  import clk_wiz_pkg::*;
#(
  parameter int unsigned LOCK_CYCLES = 64,
  parameter int unsigned FREQ_MIN    = 10,
  parameter int unsigned FREQ_MAX    = 200
) (
  input  logic        clk_100m_i,
  input  logic        arstn_i,
  input  logic [10:0] s_axi_awaddr,
  input  logic        s_axi_awvalid,
  output logic        s_axi_awready,
  input  logic [31:0] s_axi_wdata,
  input  logic [3:0]  s_axi_wstrb,
  input  logic        s_axi_wvalid,
  output logic        s_axi_wready,
  output logic [1:0]  s_axi_bresp,
  output logic        s_axi_bvalid,
  input  logic        s_axi_bready,
  input  logic [10:0] s_axi_araddr,
  input  logic        s_axi_arvalid,
  output logic        s_axi_arready,
  output logic [31:0] s_axi_rdata,
  output logic [1:0]  s_axi_rresp,
  output logic        s_axi_rvalid,
  input  logic        s_axi_rready,
  output logic        clk_out1,
  output logic        locked
);

  localparam int unsigned CntW = $clog2(LOCK_CYCLES + 1);

  logic          load;
  logic [17:0]   load_cfg;
  lock_state_e   state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [17:0]   pending_q, pending_d, active_q, active_d;
  logic          gen_clk;

  clk_wiz_axil_regs #(
    .FREQ_MIN (FREQ_MIN),
    .FREQ_MAX (FREQ_MAX)
  ) u_regs (
    .clk_100m_i    (clk_100m_i),
    .arstn_i       (arstn_i),
    .s_axi_awaddr  (s_axi_awaddr),
    .s_axi_awvalid (s_axi_awvalid),
    .s_axi_awready (s_axi_awready),
    .s_axi_wdata   (s_axi_wdata),
    .s_axi_wstrb   (s_axi_wstrb),
    .s_axi_wvalid  (s_axi_wvalid),
    .s_axi_wready  (s_axi_wready),
    .s_axi_bresp   (s_axi_bresp),
    .s_axi_bvalid  (s_axi_bvalid),
    .s_axi_bready  (s_axi_bready),
    .s_axi_araddr  (s_axi_araddr),
    .s_axi_arvalid (s_axi_arvalid),
    .s_axi_arready (s_axi_arready),
    .s_axi_rdata   (s_axi_rdata),
    .s_axi_rresp   (s_axi_rresp),
    .s_axi_rvalid  (s_axi_rvalid),
    .s_axi_rready  (s_axi_rready),
    .locked_i      (locked),
    .load_o        (load),
    .load_cfg_o    (load_cfg)
  );

  always_ff @(posedge clk_100m_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q   <= StRelock;
      cnt_q     <= CntW'(LOCK_CYCLES);
      pending_q <= CFG_RST;
      active_q  <= CFG_RST;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      active_q  <= active_d;
    end
  end

  // The last counted cycle is the one with cnt_q == 1; the new value goes active there.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pending_d = pending_q;
    active_d  = active_q;
    if (load) begin
      state_d   = StRelock;
      cnt_d     = CntW'(LOCK_CYCLES);
      pending_d = load_cfg;
    end else if (state_q == StRelock) begin
      if (cnt_q <= CntW'(1)) begin
        state_d  = StRun;
        active_d = pending_q;
      end else begin
        cnt_d = cnt_q - CntW'(1);
      end
    end
  end

  always_comb begin
    locked = (state_q == StRun);
  end

  // Behavioral clock model: starts high when lock is reached, gated low while unlocked.
  always begin : gen_model
    gen_clk = 1'b0;
    wait (locked);
    while (locked) begin
      gen_clk = 1'b1;
      #(half_period_ps(active_q));
      gen_clk = 1'b0;
      #(half_period_ps(active_q));
    end
  end

  assign clk_out1 = gen_clk & locked;

endmodule

// File: tb/tb_clk_wiz.sv
`timescale 1ps/1ps
// Directed bench for clk_wiz: register access, relock timing and generated clock period.
module tb_clk_wiz;

  logic        clk = 1'b0;
  logic        arstn;
  logic [10:0] awaddr, araddr;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic        clk_out1, locked;

  int total = 0;
  int bad   = 0;

  always #5000 clk = ~clk;

  clk_wiz dut (
    .clk_100m_i    (clk),
    .arstn_i       (arstn),
    .s_axi_awaddr  (awaddr),
    .s_axi_awvalid (awvalid),
    .s_axi_awready (awready),
    .s_axi_wdata   (wdata),
    .s_axi_wstrb   (wstrb),
    .s_axi_wvalid  (wvalid),
    .s_axi_wready  (wready),
    .s_axi_bresp   (bresp),
    .s_axi_bvalid  (bvalid),
    .s_axi_bready  (bready),
    .s_axi_araddr  (araddr),
    .s_axi_arvalid (arvalid),
    .s_axi_arready (arready),
    .s_axi_rdata   (rdata),
    .s_axi_rresp   (rresp),
    .s_axi_rvalid  (rvalid),
    .s_axi_rready  (rready),
    .clk_out1      (clk_out1),
    .locked        (locked)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic axi_write(input logic [10:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp);
    @(negedge clk);
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    check("bvalid_t1", 64'(bvalid), 64'(1));
    resp = bresp;
  endtask

  task automatic axi_read(input logic [10:0] a, output logic [31:0] d, output logic [1:0] resp);
    @(negedge clk);
    araddr = a; arvalid = 1'b1;
    @(negedge clk);
    arvalid = 1'b0;
    check("rvalid_t1", 64'(rvalid), 64'(1));
    d = rdata; resp = rresp;
  endtask

  task automatic wait_lock(input string tag, input int exp);
    int k = 0;
    while (!locked && k < 300) begin
      @(negedge clk);
      k++;
    end
    check(tag, 64'(k), 64'(exp));
  endtask

  // Measures high time and period of clk_out1 by 1 ps polling; zeros on timeout.
  task automatic measure(output longint hi, output longint per);
    longint t_r0, t_f, t_r1;
    int n = 0;
    while (clk_out1 !== 1'b0 && n < 400000) begin #1; n++; end
    while (clk_out1 !== 1'b1 && n < 400000) begin #1; n++; end
    t_r0 = $time;
    while (clk_out1 !== 1'b0 && n < 400000) begin #1; n++; end
    t_f = $time;
    while (clk_out1 !== 1'b1 && n < 400000) begin #1; n++; end
    t_r1 = $time;
    hi  = (n < 400000) ? t_f - t_r0 : 0;
    per = (n < 400000) ? t_r1 - t_r0 : 0;
  endtask

  initial begin
    #1_000_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] d;
    logic [1:0]  r;
    longint      hi, per;

    arstn = 1'b0; awaddr = '0; araddr = '0; wdata = '0; wstrb = 4'h0;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0; bready = 1'b1; rready = 1'b1;
    #2000;
    check("rst_awready", 64'(awready), 64'(0));
    check("rst_arready", 64'(arready), 64'(0));
    check("rst_bvalid", 64'(bvalid), 64'(0));
    check("rst_rvalid", 64'(rvalid), 64'(0));
    check("rst_locked", 64'(locked), 64'(0));
    check("rst_clk_out1", 64'(clk_out1), 64'(0));
    @(negedge clk); @(negedge clk);
    arstn = 1'b1;
    wait_lock("lock_after_rst", 64);
    measure(hi, per);
    check("per_100mhz", 64'(per), 64'(10000));
    axi_read(11'h004, d, r);
    check("status_locked", 64'(d), 64'(1));
    check("status_resp", 64'(r), 64'(0));
    axi_read(11'h208, d, r);
    check("cfg_rst", 64'(d), 64'(32'h64));

    // Staging a new frequency does not relock.
    axi_write(11'h208, 32'h19, 4'hF, r);
    check("cfg19_resp", 64'(r), 64'(0));
    check("cfg19_no_relock", 64'(locked), 64'(1));
    measure(hi, per);
    check("per_still_100", 64'(per), 64'(10000));
    axi_read(11'h208, d, r);
    check("cfg19_rb", 64'(d), 64'(32'h19));

    axi_write(11'h25C, 32'h3, 4'hF, r);
    check("load_unlock", 64'(locked), 64'(0));
    wait_lock("lock_after_load", 64);
    measure(hi, per);
    check("per_25mhz", 64'(per), 64'(40000));
    axi_read(11'h25C, d, r);
    check("ctrl_rb", 64'(d), 64'(32'h2));

    // Same-cycle write and read of CFG: read sees the old value.
    @(negedge clk);
    awaddr = 11'h208; wdata = 32'h6C; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    araddr = 11'h208; arvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    check("simul_bvalid", 64'(bvalid), 64'(1));
    check("simul_rvalid", 64'(rvalid), 64'(1));
    check("simul_old_cfg", 64'(rdata), 64'(32'h19));

    axi_write(11'h25C, 32'h1, 4'hF, r);
    check("load1_unlock", 64'(locked), 64'(0));
    repeat (9) @(negedge clk);
    check("relock_mid", 64'(locked), 64'(0));
    axi_write(11'h25C, 32'h1, 4'hF, r);
    wait_lock("lock_restart", 64);
    measure(hi, per);
    check("half_108mhz", 64'(hi), 64'(4630));
    check("per_108mhz", 64'(per), 64'(9260));

    // Legality boundaries.
    axi_write(11'h208, 32'h0, 4'hF, r);
    check("cfg_zero_err", 64'(r), 64'(2));
    axi_write(11'h208, 32'hC9, 4'hF, r);
    check("cfg_201_err", 64'(r), 64'(2));
    axi_write(11'h208, 32'h3E864, 4'hF, r);
    check("cfg_frac1000_err", 64'(r), 64'(2));
    axi_read(11'h208, d, r);
    check("cfg_unchanged", 64'(d), 64'(32'h6C));
    axi_write(11'h208, 32'hC8, 4'hF, r);
    check("cfg_200_ok", 64'(r), 64'(0));
    axi_write(11'h208, 32'h0A, 4'hF, r);
    check("cfg_10_ok", 64'(r), 64'(0));
    axi_write(11'h208, 32'h3E764, 4'hF, r);
    check("cfg_frac999_ok", 64'(r), 64'(0));
    axi_write(11'h208, 32'hFFFF_FF32, 4'h1, r);
    check("cfg_strb_resp", 64'(r), 64'(0));
    axi_read(11'h208, d, r);
    check("cfg_strb_rb", 64'(d), 64'(32'h3E732));

    axi_read(11'h100, d, r);
    check("unmapped_rd_resp", 64'(r), 64'(2));
    check("unmapped_rd_data", 64'(d), 64'(0));
    axi_read(11'h000, d, r);
    check("srr_rd_resp", 64'(r), 64'(2));
    axi_write(11'h100, 32'hFFFF_FFFF, 4'hF, r);
    check("unmapped_wr_resp", 64'(r), 64'(2));
    axi_write(11'h004, 32'h0, 4'hF, r);
    check("status_wr_resp", 64'(r), 64'(2));
    check("still_locked", 64'(locked), 64'(1));

    axi_write(11'h000, 32'hA, 4'hF, r);
    check("srr_resp", 64'(r), 64'(0));
    check("srr_unlock", 64'(locked), 64'(0));
    wait_lock("lock_after_srr", 64);
    measure(hi, per);
    check("per_srr", 64'(per), 64'(10000));
    axi_read(11'h208, d, r);
    check("cfg_after_srr", 64'(d), 64'(32'h64));

    // Reset mid-relock with a write response and a read response outstanding.
    axi_write(11'h208, 32'h19, 4'hF, r);
    axi_write(11'h25C, 32'h1, 4'hF, r);
    repeat (5) @(negedge clk);
    bready = 1'b0; rready = 1'b0;
    awaddr = 11'h208; wdata = 32'h20; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    araddr = 11'h208; arvalid = 1'b1;
    @(negedge clk);
    arvalid = 1'b0;
    check("pend_bvalid", 64'(bvalid), 64'(1));
    check("pend_rdata", 64'(rdata), 64'(32'h20));
    arstn = 1'b0;
    #1000;
    check("arst_bvalid", 64'(bvalid), 64'(0));
    check("arst_rvalid", 64'(rvalid), 64'(0));
    check("arst_awready", 64'(awready), 64'(0));
    check("arst_rdata", 64'(rdata), 64'(0));
    check("arst_locked", 64'(locked), 64'(0));
    check("arst_clk_out1", 64'(clk_out1), 64'(0));
    bready = 1'b1; rready = 1'b1;
    @(negedge clk);
    arstn = 1'b1;
    wait_lock("lock_after_arst", 64);
    axi_read(11'h208, d, r);
    check("cfg_after_arst", 64'(d), 64'(32'h64));
    measure(hi, per);
    check("per_after_arst", 64'(per), 64'(10000));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
